// File: rtl/seg7_pkg.sv
// Shared 7-segment encodings, run-state enum and BCD helpers
// for the BCD display counter.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] v
  );
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low gfedcba segments.
// Non-decimal codes blank the display.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_counter.sv
// Multi-digit BCD up/down counter with debounced run/load keys
// and registered 7-segment outputs.
module bcd_display_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50_000_000,
  parameter int DEBOUNCE = 500_000
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  input  logic [1:0]          KEY,
  input  logic [9:0]          SW,
  output logic [7*DIGITS-1:0] HEX,
  output logic [1:0]          LEDR
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEBOUNCE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);

  logic [1:0] press;

  // Counter tracks consecutive raw samples that differ from the
  // accepted level; the last one of the run flips the level.
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          lvl;
    logic [DW-1:0] cnt;
    logic          accept;

    assign accept   = (KEY[k] != lvl) && (cnt == DMAX);
    assign press[k] = accept && !KEY[k];

    always_ff @(posedge CLOCK_50) begin
      if (RST) begin
        lvl <= 1'b1;
        cnt <= '0;
      end else if (KEY[k] == lvl) begin
        cnt <= '0;
      end else if (accept) begin
        lvl <= KEY[k];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  run_state_t state, state_nx;
  logic       running;
  logic       load;
  logic       tick;
  logic [PW-1:0] pre;

  assign running = (state == RUNNING);
  assign load    = press[1];
  assign tick    = running && (pre == PMAX);

  always_ff @(posedge CLOCK_50) begin
    if (RST) state <= STOPPED;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (press[0]) begin
      state_nx = running ? STOPPED : RUNNING;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      pre <= '0;
    end else if (load || (press[0] && !running)) begin
      pre <= '0;
    end else if (running) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  logic [DIGITS-1:0][3:0] cnt, cnt_step;
  logic                   carry;
  logic                   wrap;

  // Ripple carry/borrow; a carry out of the top digit is a wrap.
  always_comb begin
    cnt_step = cnt;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (SW[9]) begin
          if (cnt[i] == 4'd9) begin
            cnt_step[i] = 4'd0;
          end else begin
            cnt_step[i] = cnt[i] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (cnt[i] == 4'd0) begin
            cnt_step[i] = 4'd9;
          end else begin
            cnt_step[i] = cnt[i] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        cnt <= {DIGITS{bcd_clamp(SW[3:0])}};
      end else if (tick) begin
        cnt  <= cnt_step;
        wrap <= carry;
      end
    end
  end

  logic [7*DIGITS-1:0] seg_nx;
  logic [7*DIGITS-1:0] hex_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    seg7_decoder u_dec (
      .bcd (cnt[i]),
      .seg (seg_nx[7*i +: 7])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) hex_q <= {DIGITS{SEG_0}};
    else     hex_q <= seg_nx;
  end

  logic sw_unused;
  assign sw_unused = ^SW[8:4];

  assign HEX  = hex_q;
  assign LEDR = {wrap, running};

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed + randomized bench for bcd_display_counter against
// an arithmetic reference model (DIGITS=2, PRESCALE=4, DEBOUNCE=3).
module tb_bcd_display_counter;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int DEBOUNCE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  key;
  logic [9:0]  sw;
  logic [13:0] hex;
  logic [1:0]  ledr;

  bcd_display_counter #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .KEY      (key),
    .SW       (sw),
    .HEX      (hex),
    .LEDR     (ledr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] enc [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  function automatic logic [13:0] hex2(input int n);
    return {enc[(n / 10) % 10], enc[n % 10]};
  endfunction

  // Reference model state: count as an integer 0..99
  int          m_cnt;
  int          m_pre;
  bit          m_run;
  bit          m_wrap;
  bit          m_lvl [2];
  bit          m_prev [2];
  int          m_rl [2];
  logic [13:0] exp_hex;
  logic [1:0]  exp_led;

  task automatic model_step();
    bit p [2];
    bit r;
    bit tk;
    int v;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_run = 0; m_wrap = 0;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] = 1; m_prev[k] = 1; m_rl[k] = 0;
      end
      exp_hex = hex2(0);
      exp_led = 2'b00;
      return;
    end
    exp_hex = hex2(m_cnt);
    for (int k = 0; k < 2; k++) begin
      r = key[k];
      if (r == m_prev[k]) m_rl[k]++;
      else m_rl[k] = 1;
      m_prev[k] = r;
      p[k] = 0;
      if (r != m_lvl[k] && m_rl[k] >= DEBOUNCE) begin
        m_lvl[k] = r;
        p[k] = !r;
      end
    end
    tk = m_run && (m_pre == PRESCALE - 1);
    m_wrap = 0;
    if (p[1]) begin
      v = (sw[3:0] > 4'd9) ? 9 : int'(sw[3:0]);
      m_cnt = v * 10 + v;
    end else if (tk) begin
      if (sw[9]) begin
        m_wrap = (m_cnt == 99);
        m_cnt = (m_cnt + 1) % 100;
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt = (m_cnt + 99) % 100;
      end
    end
    if (m_run) m_pre = (m_pre + 1) % PRESCALE;
    if (p[1]) m_pre = 0;
    if (p[0]) begin
      m_run = !m_run;
      if (m_run) m_pre = 0;
    end
    exp_led = {m_wrap, m_run};
  endtask

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_hex", 16'(hex), 16'(exp_hex));
    check("model_ledr", 16'(ledr), 16'(exp_led));
  endtask

  task automatic wait_hex(input int n, input int budget, input string tag);
    int i = 0;
    while (hex !== hex2(n) && i < budget) begin
      step();
      i++;
    end
    check(tag, 16'(hex), 16'(hex2(n)));
  endtask

  task automatic wait_wrap(input int budget, input string tag);
    int i = 0;
    while (ledr[1] !== 1'b1 && i < budget) begin
      step();
      i++;
    end
    check(tag, 16'(ledr[1]), 16'(1'b1));
  endtask

  initial begin
    rst = 1'b1;
    key = 2'b11;
    sw  = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_hex", 16'(hex), 16'(14'b1000000_1000000));
    check("rst_ledr", 16'(ledr), 16'(2'b00));
    repeat (5) step();
    check("no_press_after_rst", 16'(ledr), 16'(2'b00));

    key[0] = 1'b0;
    step();
    step();
    key[0] = 1'b1;
    repeat (5) step();
    check("glitch_no_toggle", 16'(ledr[0]), 16'(1'b0));

    sw[9]  = 1'b1;
    key[0] = 1'b0;
    repeat (3) step();
    check("toggle_run", 16'(ledr[0]), 16'(1'b1));
    repeat (4) step();
    check("up_before_tick", 16'(hex), 16'(hex2(0)));
    step();
    check("up_01", 16'(hex), 16'(hex2(1)));
    key[0] = 1'b1;
    repeat (35) step();
    check("up_09", 16'(hex), 16'(hex2(9)));
    step();
    check("up_10", 16'(hex), 16'(hex2(10)));
    wait_hex(99, 400, "up_99");
    wait_wrap(8, "wrap_up_pulse");
    step();
    check("wrap_up_len", 16'(ledr[1]), 16'(1'b0));
    check("wrap_up_00", 16'(hex), 16'(hex2(0)));

    sw[9] = 1'b0;
    wait_wrap(8, "wrap_dn_pulse");
    step();
    check("wrap_dn_99", 16'(hex), 16'(hex2(99)));
    check("wrap_dn_len", 16'(ledr[1]), 16'(1'b0));
    wait_hex(98, 8, "dn_98");

    sw[3:0] = 4'd12;
    key[1]  = 1'b0;
    repeat (4) step();
    check("load_clamp_99", 16'(hex), 16'(hex2(99)));

    key = 2'b10;
    repeat (3) step();
    check("stop", 16'(ledr[0]), 16'(1'b0));
    key[0] = 1'b1;
    repeat (3) step();
    key[1] = 1'b0;
    repeat (4) step();
    check("load_stopped", 16'(hex), 16'(hex2(99)));
    key[1] = 1'b1;
    repeat (3) step();

    sw[9]  = 1'b1;
    key[0] = 1'b0;
    repeat (3) step();
    step();
    key[1] = 1'b0;
    repeat (3) step();
    check("coin_no_wrap", 16'(ledr[1]), 16'(1'b0));
    step();
    check("coin_hex_99", 16'(hex), 16'(hex2(99)));
    check("coin_no_wrap2", 16'(ledr[1]), 16'(1'b0));
    key = 2'b11;
    repeat (3) step();

    wait_hex(36, 400, "at_36");
    key[0] = 1'b0;
    repeat (3) step();
    check("stopped_at_37", 16'(ledr[0]), 16'(1'b0));
    key[0] = 1'b1;
    repeat (20) step();
    check("idle_37", 16'(hex), 16'(hex2(37)));
    check("idle_stopped", 16'(ledr[0]), 16'(1'b0));
    key[0] = 1'b0;
    repeat (3) step();
    check("resume_run", 16'(ledr[0]), 16'(1'b1));
    repeat (4) step();
    check("resume_early", 16'(hex), 16'(hex2(37)));
    step();
    check("resume_38", 16'(hex), 16'(hex2(38)));
    key[0] = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) key[0] = ~key[0];
      if ($urandom_range(7) == 0) key[1] = ~key[1];
      if ($urandom_range(15) == 0) sw = 10'($urandom);
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
